sram_port_arbiter: RTL and testbench

- Shares one single-port `sram` instance between up to NUM_REQ requesters, e.g. the matcher's vocab scan, the encoder's read pointer and the output writer.
- Round-robin arbitration, with an optional lock that keeps ownership across multi-cycle bursts.
- Sits between the requesters and the `sram` port.
- Read data returns one cycle after the grant, tagged per requester by `rvalid`.

---
 rtl/sram_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin sharing of one single-port SRAM among NUM_REQ requesters.
// Optional burst ownership (lock input, OWNED state) is built only when SRAM_ARB_LOCK_EN is defined;
// otherwise the lock input is ignored and every grant advances the priority pointer.
module sram_port_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               lock,
    input  logic [NUM_REQ-1:0]               we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               rvalid,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             mem_cs,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0]            mem_rdata
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned LAST  = NUM_REQ - 1;

    // Wrap-around increment; explicit compare keeps non-power-of-2 counts in range
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        if (32'(i) >= LAST) begin
            return '0;
        end
        return i + IDX_W'(1);
    endfunction

    logic [IDX_W-1:0]   prio_q;
    logic [NUM_REQ-1:0] rvalid_q;
    logic [NUM_REQ-1:0] rvalid_d;

    logic               win_any;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   scan_idx;

    logic               gnt_any;
    logic               gnt_vld;
    logic [IDX_W-1:0]   gnt_idx;

`ifdef SRAM_ARB_LOCK_EN
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] owner_q;
`else
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    // Round-robin search: first requester at or after prio_q
    always_comb begin
        win_any  = 1'b0;
        win_idx  = '0;
        scan_idx = prio_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!win_any && req[scan_idx]) begin
                win_any = 1'b1;
                win_idx = scan_idx;
            end
            scan_idx = idx_inc(scan_idx);
        end
    end

    // Grant select: the owner during a locked burst, otherwise the round-robin winner
    always_comb begin
        gnt_idx = win_idx;
        gnt_any = win_any;
`ifdef SRAM_ARB_LOCK_EN
        if (state_q == OWNED) begin
            gnt_idx = owner_q;
            gnt_any = req[owner_q];
        end
`endif
        gnt_vld = gnt_any & rst_n;
        gnt     = '0;
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // SRAM port mux: granted requester's slices, all zero when idle
    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_vld) begin
            mem_cs    = 1'b1;
            mem_we    = we[gnt_idx];
            mem_addr  = addr[32'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata = wdata[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign rvalid_d = gnt & ~we;

    // Read-valid tag, one cycle behind the read grant to match SRAM latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= '0;
        end else begin
            rvalid_q <= rvalid_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = mem_rdata;

    // Arbitration state: priority pointer and, with locking, burst ownership
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q  <= '0;
`ifdef SRAM_ARB_LOCK_EN
            state_q <= IDLE;
            owner_q <= '0;
`endif
        end else begin
`ifdef SRAM_ARB_LOCK_EN
            case (state_q)
                IDLE: begin
                    if (win_any) begin
                        prio_q <= idx_inc(win_idx);
                        if (lock[win_idx]) begin
                            owner_q <= win_idx;
                            state_q <= OWNED;
                        end
                    end
                end
                OWNED: begin
                    if (!lock[owner_q] || !req[owner_q]) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
`else
            if (win_any) begin
                prio_q <= idx_inc(win_idx);
            end
`endif
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter (NUM_REQ=2, 4-bit address, 8-bit data) with a behavioural SRAM.
// The locked-burst scenario expects ownership when SRAM_ARB_LOCK_EN is defined, plain rotation otherwise.
module tb_sram_port_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR-1:0]     lock;
    logic [NR-1:0]     we;
    logic [NR*AW-1:0]  addr;
    logic [NR*DW-1:0]  wdata;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     rvalid;
    logic [DW-1:0]     rdata;
    logic              mem_cs;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    logic [DW-1:0]     sram [0:(1<<AW)-1];

    int errors;
    int checks;

    sram_port_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM with registered read output
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [NR-1:0] exp_g;
    logic [NR-1:0] prev_g;
    logic [DW-1:0] prev_d;
    logic [DW-1:0] cur_d;

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < (1 << AW); i++) sram[i] = 8'h00;
        sram[5] = 8'hA7;
        sram[0] = 8'h10;
        sram[1] = 8'h11;
        sram[2] = 8'h12;
        sram[3] = 8'h13;
        sram[4] = 8'h14;
        mem_rdata = '0;
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;

        // Reset then idle
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_cs", 32'(mem_cs), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("idle_gnt", 32'(gnt), 0);
            chk("idle_rvalid", 32'(rvalid), 0);
            chk("idle_cs", 32'(mem_cs), 0);
            step();
        end

        // Single read of address 5 by requester 0
        req = 2'b01; we = 2'b00; addr[3:0] = 4'h5;
        @(negedge clk);
        chk("rd_gnt", 32'(gnt), 32'h1);
        chk("rd_cs", 32'(mem_cs), 1);
        chk("rd_we", 32'(mem_we), 0);
        chk("rd_addr", 32'(mem_addr), 5);
        step();
        req = 2'b00;
        @(negedge clk);
        chk("rd_rvalid", 32'(rvalid), 32'h1);
        chk("rd_rdata", 32'(rdata), 32'hA7);
        chk("rd_gnt_off", 32'(gnt), 0);
        step();

        // Write 3C to address 2 by requester 1, no rvalid, then read it back
        req = 2'b10; we = 2'b10; addr[7:4] = 4'h2; wdata[15:8] = 8'h3C;
        @(negedge clk);
        chk("wr_gnt", 32'(gnt), 32'h2);
        chk("wr_we", 32'(mem_we), 1);
        chk("wr_addr", 32'(mem_addr), 2);
        chk("wr_wdata", 32'(mem_wdata), 32'h3C);
        step();
        we = 2'b00;
        @(negedge clk);
        chk("wr_no_rvalid", 32'(rvalid), 0);
        chk("rb_gnt", 32'(gnt), 32'h2);
        chk("rb_we", 32'(mem_we), 0);
        step();
        req = 2'b00;
        @(negedge clk);
        chk("rb_rvalid", 32'(rvalid), 32'h2);
        chk("rb_rdata", 32'(rdata), 32'h3C);
        step();

        // Round-robin contention, both reading (req0 -> addr 5, req1 -> addr 2)
        req = 2'b11; we = 2'b00; addr[3:0] = 4'h5; addr[7:4] = 4'h2;
        prev_g = 2'b00;
        for (int c = 0; c < 6; c++) begin
            exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            chk("rr_gnt", 32'(gnt), 32'(exp_g));
            chk("rr_rvalid", 32'(rvalid), 32'(prev_g));
            if (prev_g != 2'b00)
                chk("rr_rdata", 32'(rdata), (prev_g == 2'b01) ? 32'hA7 : 32'h3C);
            prev_g = exp_g;
            step();
        end
        req = 2'b00;
        @(negedge clk);
        chk("rr_last_rvalid", 32'(rvalid), 32'h2);
        chk("rr_last_rdata", 32'(rdata), 32'h3C);
        step();

        // Requester 0 once so the pointer favours requester 1
        req = 2'b01; addr[3:0] = 4'h5;
        @(negedge clk);
        chk("pre_gnt", 32'(gnt), 32'h1);
        step();

        // Requester 1 burst over addresses 0..3 with lock, requester 0 competing
        prev_g = 2'b01;
        prev_d = 8'hA7;
        for (int c = 0; c < 5; c++) begin
            req = 2'b11;
            addr[7:4] = 4'(c);
            lock = (c < 3) ? 2'b10 : 2'b00;
`ifdef SRAM_ARB_LOCK_EN
            exp_g = (c < 4) ? 2'b10 : 2'b01;
`else
            exp_g = (c % 2 == 0) ? 2'b10 : 2'b01;
`endif
            cur_d = (exp_g == 2'b10) ? sram[c] : 8'hA7;
            @(negedge clk);
            chk("lk_gnt", 32'(gnt), 32'(exp_g));
            chk("lk_rvalid", 32'(rvalid), 32'(prev_g));
            chk("lk_rdata", 32'(rdata), 32'(prev_d));
            if (exp_g == 2'b10) chk("lk_addr", 32'(mem_addr), 32'(c));
            prev_g = exp_g;
            prev_d = cur_d;
            step();
        end
        req = 2'b00; lock = 2'b00;
        @(negedge clk);
        chk("lk_end_rvalid", 32'(rvalid), 32'(prev_g));
        chk("lk_end_rdata", 32'(rdata), 32'(prev_d));
        step();

        // Reset mid-burst with a read in flight
        req = 2'b01; lock = 2'b01; addr[3:0] = 4'h5;
        @(negedge clk);
        chk("mb_gnt0", 32'(gnt), 32'h1);
        step();
        @(negedge clk);
        chk("mb_gnt1", 32'(gnt), 32'h1);
        chk("mb_rvalid1", 32'(rvalid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mb_rst_gnt", 32'(gnt), 0);
        chk("mb_rst_cs", 32'(mem_cs), 0);
        chk("mb_rst_rvalid", 32'(rvalid), 0);
        step();
        chk("mb_drop_rvalid", 32'(rvalid), 0);
        rst_n = 1'b1;
        req = 2'b11; lock = 2'b00; addr[7:4] = 4'h2;
        @(negedge clk);
        chk("mb_first_gnt", 32'(gnt), 32'h1);
        chk("mb_first_rvalid", 32'(rvalid), 0);
        step();
        @(negedge clk);
        chk("mb_second_gnt", 32'(gnt), 32'h2);
        chk("mb_second_rvalid", 32'(rvalid), 32'h1);
        chk("mb_second_rdata", 32'(rdata), 32'hA7);
        step();
        req = 2'b00;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
